// File: rtl/axi_rd_responder_pkg.sv
// Shared types and constants for the AXI read responder.
//   rd_entry_t : one request-table entry. Field widths are fixed maxima so the
//                struct can live in a package; instances zero-extend their
//                parameterised AR fields into it (ID <= 16 bits, ADDR <= 64 bits).
//   RESP_*     : R response encodings used by the responder.
//   ORDER_*    : encodings for the ORDER_MODE parameter.
//   rd_state_e : responder FSM state encoding.
package axi_rd_responder_pkg;

    localparam int ENT_ID_W   = 16;
    localparam int ENT_ADDR_W = 64;
    localparam int ENT_LEN_W  = 8;
    localparam int ENT_SIZE_W = 3;
    localparam int ENT_LAT_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ORDER_OLDEST = 0;
    localparam int ORDER_NEWEST = 1;

    typedef struct packed {
        logic [ENT_ID_W-1:0]   id;
        logic [ENT_ADDR_W-1:0] addr;
        logic [ENT_LEN_W-1:0]  len;
        logic [ENT_SIZE_W-1:0] size;
        logic [ENT_LAT_W-1:0]  lat;
    } rd_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_rd_responder_table.sv
// rd_req_table: outstanding read-request storage and eligible-entry select.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alloc_en, alloc_entry    write a new entry into the lowest free slot
//   free_en, free_idx        release an entry (may coincide with alloc)
//   full                     every slot occupied (registered occupancy)
//   sel_valid, sel_idx,      oldest or newest eligible entry (latency
//   sel_entry                counter at zero), chosen by ORDER_MODE
// Each valid entry carries an age rank: 0 is the newest, ranks stay compact
// in 0..DEPTH-1 so comparing ranks gives accept order without wrap issues.
module rd_req_table
    import axi_rd_responder_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int IDX_W      = 2,
    parameter int ORDER_MODE = ORDER_NEWEST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  rd_entry_t        alloc_entry,
    input  logic             free_en,
    input  logic [IDX_W-1:0] free_idx,
    output logic             full,
    output logic             sel_valid,
    output logic [IDX_W-1:0] sel_idx,
    output rd_entry_t        sel_entry
);

    logic [DEPTH-1:0] valid_q, valid_d;
    rd_entry_t        ent_q [DEPTH];
    rd_entry_t        ent_d [DEPTH];
    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] age_d [DEPTH];
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] best_age;
    logic             found_free;

    assign full = &valid_q;

    always_comb begin
        alloc_idx  = '0;
        found_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found_free) begin
                alloc_idx  = IDX_W'(i);
                found_free = 1'b1;
            end
        end
    end

    // Surviving entries age by one on an accept; entries older than a freed
    // one close the gap it leaves.
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        age_d   = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ent_q[i].lat != '0)) begin
                ent_d[i].lat = ent_q[i].lat - ENT_LAT_W'(1);
            end
            if (free_en && (free_idx == IDX_W'(i))) begin
                valid_d[i] = 1'b0;
            end else if (valid_q[i]) begin
                age_d[i] = age_q[i] + IDX_W'(alloc_en)
                         - IDX_W'(free_en && (age_q[i] > age_q[free_idx]));
            end
        end
        if (alloc_en) begin
            valid_d[alloc_idx] = 1'b1;
            ent_d[alloc_idx]   = alloc_entry;
            age_d[alloc_idx]   = '0;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ent_q[i].lat == '0)) begin
                if (!sel_valid ||
                    ((ORDER_MODE == ORDER_NEWEST) ? (age_q[i] < best_age)
                                                  : (age_q[i] > best_age))) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                    best_age  = age_q[i];
                end
            end
        end
    end

    assign sel_entry = ent_q[sel_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI read-channel responder that answers every AR with
// synthetic data {id, beat address}, optionally out of order.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ar_*                AR request (slave side); ar_burst/ar_qos ignored
//   ar_ready            request table not full
//   r_*                 R beats (master side), all registered
//   r_ready             downstream accepts the current beat
//
// state    | meaning
// ST_IDLE  | no burst in flight; picks an eligible table entry if any
// ST_BURST | r_valid high, stepping beats of the selected entry on r_ready
module axi_rd_responder
    import axi_rd_responder_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int RESP_WIDTH      = 2,
    parameter int LEN_WIDTH       = 8,
    parameter int SIZE_WIDTH      = 3,
    parameter int BURST_WIDTH     = 2,
    parameter int QOS_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int READ_LATENCY    = 2,
    parameter int ORDER_MODE      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ar_valid,
    input  logic [ID_WIDTH-1:0]    ar_id,
    input  logic [ADDR_WIDTH-1:0]  ar_addr,
    input  logic [LEN_WIDTH-1:0]   ar_len,
    input  logic [SIZE_WIDTH-1:0]  ar_size,
    input  logic [BURST_WIDTH-1:0] ar_burst,
    input  logic [QOS_WIDTH-1:0]   ar_qos,
    output logic                   ar_ready,
    output logic                   r_valid,
    output logic [ID_WIDTH-1:0]    r_id,
    output logic [DATA_WIDTH-1:0]  r_data,
    output logic [RESP_WIDTH-1:0]  r_resp,
    output logic                   r_last,
    input  logic                   r_ready
);

    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic             tbl_full;
    logic             alloc_en;
    logic             free_en;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    rd_entry_t        sel_entry;
    rd_entry_t        alloc_entry;

    rd_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    rd_entry_t              cur_q, cur_d;
    logic [ENT_LEN_W-1:0]   beat_q, beat_d, beat_nxt;
    logic                   r_valid_q, r_valid_d;
    logic [ID_WIDTH-1:0]    r_id_q, r_id_d;
    logic [DATA_WIDTH-1:0]  r_data_q, r_data_d;
    logic [RESP_WIDTH-1:0]  r_resp_q, r_resp_d;
    logic                   r_last_q, r_last_d;

    logic unused_bits;
    assign unused_bits = ^{ar_burst, ar_qos, cur_q};

    function automatic logic [DATA_WIDTH-1:0] pack_data(
        input logic [ID_WIDTH-1:0]   id,
        input logic [ADDR_WIDTH-1:0] addr
    );
        return DATA_WIDTH'({id, addr});
    endfunction

    // INCR only; the sum wraps naturally at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ENT_LEN_W-1:0]  beat,
        input logic [ENT_SIZE_W-1:0] size
    );
        return base + (ADDR_WIDTH'(beat) << size);
    endfunction

    assign ar_ready = !tbl_full;
    assign alloc_en = ar_valid && !tbl_full;

    always_comb begin
        alloc_entry      = '0;
        alloc_entry.id   = ENT_ID_W'(ar_id);
        alloc_entry.addr = ENT_ADDR_W'(ar_addr);
        alloc_entry.len  = ENT_LEN_W'(ar_len);
        alloc_entry.size = ENT_SIZE_W'(ar_size);
        alloc_entry.lat  = ENT_LAT_W'(READ_LATENCY);
    end

    rd_req_table #(
        .DEPTH      (MAX_OUTSTANDING),
        .IDX_W      (IDX_W),
        .ORDER_MODE (ORDER_MODE)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (alloc_en),
        .alloc_entry (alloc_entry),
        .free_en     (free_en),
        .free_idx    (idx_q),
        .full        (tbl_full),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .sel_entry   (sel_entry)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        beat_d    = beat_q;
        r_valid_d = r_valid_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        free_en   = 1'b0;
        beat_nxt  = beat_q + ENT_LEN_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d   = ST_BURST;
                    idx_d     = sel_idx;
                    cur_d     = sel_entry;
                    beat_d    = '0;
                    r_valid_d = 1'b1;
                    r_id_d    = sel_entry.id[ID_WIDTH-1:0];
                    r_data_d  = pack_data(sel_entry.id[ID_WIDTH-1:0],
                                          sel_entry.addr[ADDR_WIDTH-1:0]);
                    r_resp_d  = RESP_WIDTH'(sel_entry.addr[ADDR_WIDTH-1] ? RESP_SLVERR
                                                                           : RESP_OKAY);
                    r_last_d  = (sel_entry.len == '0);
                end
            end
            ST_BURST: begin
                if (r_ready) begin
                    if (r_last_q) begin
                        free_en   = 1'b1;
                        state_d   = ST_IDLE;
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                    end else begin
                        beat_d   = beat_nxt;
                        r_data_d = pack_data(cur_q.id[ID_WIDTH-1:0],
                                             beat_addr(cur_q.addr[ADDR_WIDTH-1:0],
                                                       beat_nxt, cur_q.size));
                        r_last_d = (beat_nxt == cur_q.len);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cur_q     <= '0;
            beat_q    <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            beat_q    <= beat_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
        end
    end

    assign r_valid = r_valid_q;
    assign r_id    = r_id_q;
    assign r_data  = r_data_q;
    assign r_resp  = r_resp_q;
    assign r_last  = r_last_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder with default parameters (newest-first).
module tb_axi_rd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic [3:0]  ar_id = '0;
    logic [31:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic [3:0]  ar_qos = '0;
    logic        ar_ready;
    logic        r_valid;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int w;

    always #5 clk = ~clk;

    axi_rd_responder dut (
        .clk      (clk),
        .rst      (rst),
        .ar_valid (ar_valid),
        .ar_id    (ar_id),
        .ar_addr  (ar_addr),
        .ar_len   (ar_len),
        .ar_size  (ar_size),
        .ar_burst (ar_burst),
        .ar_qos   (ar_qos),
        .ar_ready (ar_ready),
        .r_valid  (r_valid),
        .r_id     (r_id),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_last   (r_last),
        .r_ready  (r_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        int n;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size;
        ar_burst = 2'b01; ar_qos = 4'hf; ar_valid = 1'b1;
        n = 0;
        while (!ar_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_val("ar_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [3:0] id, input logic [63:0] data,
                               input logic [1:0] resp, input logic last, output int waited);
        waited = 0;
        r_ready = 1'b1;
        while (!r_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!r_valid) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check_val({tag, "_id"},   64'(r_id),   64'(id));
            check_val({tag, "_data"}, r_data,      data);
            check_val({tag, "_resp"}, 64'(r_resp), 64'(resp));
            check_val({tag, "_last"}, 64'(r_last), 64'(last));
        end
        @(negedge clk);
    endtask

    logic [63:0] exp4 [4];
    logic [63:0] exps [4];
    logic [3:0]  pat = 4'b1001;
    logic [63:0] held_data;
    logic        held_last;
    logic        stalled;
    int          k;
    int          n;

    initial begin
        exp4[0] = 64'h0000_0005_0000_4000;
        exp4[1] = 64'h0000_0005_0000_4008;
        exp4[2] = 64'h0000_0005_0000_4010;
        exp4[3] = 64'h0000_0005_0000_4018;
        exps[0] = 64'h0000_0002_0000_0500;
        exps[1] = 64'h0000_0002_0000_0504;
        exps[2] = 64'h0000_0002_0000_0508;
        exps[3] = 64'h0000_0002_0000_050c;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_r_valid",  64'(r_valid),  64'd0);
        check_val("rst_r_last",   64'(r_last),   64'd0);
        check_val("rst_r_id",     64'(r_id),     64'd0);
        check_val("rst_r_data",   r_data,        64'd0);
        check_val("rst_r_resp",   64'(r_resp),   64'd0);
        check_val("rst_ar_ready", 64'(ar_ready), 64'd1);

        // single beat, latency
        send_ar(4'd0, 32'h1000, 8'd0, 3'd0);
        expect_beat("single", 4'd0, 64'h0000_0000_0000_1000, 2'b00, 1'b1, w);
        check_val("single_latency", 64'(w >= 2), 64'd1);
        check_val("single_no_extra", 64'(r_valid), 64'd0);

        // newest-first: a blocker holds the FSM while two requests queue up
        r_ready = 1'b0;
        send_ar(4'd1, 32'h0100, 8'd0, 3'd0);
        send_ar(4'd3, 32'h2000, 8'd0, 3'd0);
        send_ar(4'd3, 32'h3000, 8'd0, 3'd0);
        repeat (6) @(negedge clk);
        expect_beat("ord_blk", 4'd1, 64'h0000_0001_0000_0100, 2'b00, 1'b1, w);
        expect_beat("ord_new", 4'd3, 64'h0000_0003_0000_3000, 2'b00, 1'b1, w);
        expect_beat("ord_old", 4'd3, 64'h0000_0003_0000_2000, 2'b00, 1'b1, w);

        // 4-beat INCR, size 3
        send_ar(4'd5, 32'h4000, 8'd3, 3'd3);
        for (int b = 0; b < 4; b++)
            expect_beat($sformatf("b4_%0d", b), 4'd5, exp4[b], 2'b00, (b == 3), w);

        // address wrap with SLVERR on every beat
        send_ar(4'd9, 32'hffff_fff8, 8'd1, 3'd3);
        expect_beat("wrap0", 4'd9, 64'h0000_0009_ffff_fff8, 2'b10, 1'b0, w);
        expect_beat("wrap1", 4'd9, 64'h0000_0009_0000_0000, 2'b10, 1'b1, w);

        // back-pressure 1-0-0-1 during a 4-beat burst
        r_ready = 1'b0;
        send_ar(4'd2, 32'h0500, 8'd3, 3'd2);
        n = 0;
        while (!r_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        stalled = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            r_ready = (c < 4) ? pat[c] : 1'b1;
            if (stalled) begin
                check_val("stall_valid", 64'(r_valid), 64'd1);
                check_val("stall_data",  r_data,       held_data);
                check_val("stall_last",  64'(r_last),  64'(held_last));
            end
            if (r_valid && r_ready) begin
                check_val($sformatf("bp_data_%0d", k), r_data, exps[k]);
                check_val($sformatf("bp_last_%0d", k), 64'(r_last), 64'(k == 3));
                k++;
                stalled = 1'b0;
            end else if (r_valid) begin
                stalled   = 1'b1;
                held_data = r_data;
                held_last = r_last;
            end
            @(negedge clk);
        end
        check_val("bp_beat_count", 64'(k), 64'd4);
        check_val("bp_no_dup", 64'(r_valid), 64'd0);

        // fill the table, free one while a new AR waits
        r_ready = 1'b0;
        send_ar(4'd1, 32'h0000_0100, 8'd0, 3'd0);
        send_ar(4'd2, 32'h8000_0000, 8'd0, 3'd0);
        send_ar(4'd3, 32'h0000_0300, 8'd0, 3'd0);
        send_ar(4'd4, 32'h0000_0400, 8'd0, 3'd0);
        check_val("full_ar_ready", 64'(ar_ready), 64'd0);
        repeat (4) @(negedge clk);
        check_val("full_served_valid", 64'(r_valid), 64'd1);
        check_val("full_served_data",  r_data,       64'h0000_0001_0000_0100);
        ar_id = 4'd5; ar_addr = 32'h0000_0500; ar_len = 8'd0; ar_size = 3'd0;
        ar_valid = 1'b1;
        r_ready = 1'b1;
        @(negedge clk);
        check_val("free_ar_ready", 64'(ar_ready), 64'd1);
        check_val("free_bubble",   64'(r_valid),  64'd0);
        r_ready = 1'b0;
        @(negedge clk);
        ar_valid = 1'b0;
        check_val("refill_ar_ready", 64'(ar_ready), 64'd0);
        repeat (6) @(negedge clk);
        expect_beat("drain4", 4'd4, 64'h0000_0004_0000_0400, 2'b00, 1'b1, w);
        expect_beat("drain5", 4'd5, 64'h0000_0005_0000_0500, 2'b00, 1'b1, w);
        expect_beat("drain3", 4'd3, 64'h0000_0003_0000_0300, 2'b00, 1'b1, w);
        expect_beat("drain2", 4'd2, 64'h0000_0002_8000_0000, 2'b10, 1'b1, w);

        // reset mid-burst
        r_ready = 1'b0;
        send_ar(4'd6, 32'h0600, 8'd3, 3'd0);
        n = 0;
        while (!r_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_valid", 64'(r_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_valid",    64'(r_valid),  64'd0);
        check_val("mid_rst_data",     r_data,        64'd0);
        check_val("mid_rst_ar_ready", 64'(ar_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        r_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check_val($sformatf("post_rst_idle_%0d", c), 64'(r_valid), 64'd0);
            @(negedge clk);
        end
        send_ar(4'd7, 32'h0700, 8'd0, 3'd0);
        expect_beat("post_rst", 4'd7, 64'h0000_0007_0000_0700, 2'b00, 1'b1, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
